// File: rtl/irq_priority_ctrl_if.sv
// irq_priority_ctrl_if
// Bundles the peripheral interrupt lines, mask programming, and the
// req/ack/eoi handshake between the interrupt controller and the core.
//   master : core / peripheral side (drives sources, mask, ack, eoi)
//   slave  : controller side (drives request, vector, status views)
// Signals:
//   irq[NUM_IRQ]        maskable source lines, bit 0 highest priority
//   nmi                 non-maskable source
//   intd                global maskable-interrupt disable
//   mask_we/mask_wdata  mask register write port (1 = source disabled)
//   int_ack             core accepts current request
//   eoi                 core finished servicing current interrupt
//   int_req             request to core
//   int_vector          index of requesting maskable source, 0 for NMI
//   int_is_nmi          current request/service is NMI
//   in_service          core is inside a handler
//   pending / mask      register views
interface irq_priority_ctrl_if #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 3
);
  logic [NUM_IRQ-1:0] irq;
  logic               nmi;
  logic               intd;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic               int_ack;
  logic               eoi;
  logic               int_req;
  logic [VEC_W-1:0]   int_vector;
  logic               int_is_nmi;
  logic               in_service;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;

  modport master (
    output irq, nmi, intd, mask_we, mask_wdata, int_ack, eoi,
    input  int_req, int_vector, int_is_nmi, in_service, pending, mask
  );

  modport slave (
    input  irq, nmi, intd, mask_we, mask_wdata, int_ack, eoi,
    output int_req, int_vector, int_is_nmi, in_service, pending, mask
  );
endinterface

// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl
// Latches and prioritises NUM_IRQ maskable sources plus one NMI and hands
// one vectored request at a time to the core over a req/ack/eoi handshake.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    irq_priority_ctrl_if.slave (sources, mask port, handshake, status)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no request outstanding; picks NMI first, else lowest eligible
// REQ     | int_req high, vector/is_nmi frozen until int_ack
// SERVICE | core in handler (in_service); waits for eoi, no nesting
module irq_priority_ctrl #(
  parameter int NUM_IRQ   = 8,
  parameter int VEC_W     = 3,
  parameter bit EDGE_MODE = 1'b1
) (
  input logic clk,
  input logic reset,
  irq_priority_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state, stateNext;
  logic [NUM_IRQ-1:0] irqDly;
  logic [NUM_IRQ-1:0] pendReg;
  logic [NUM_IRQ-1:0] maskReg;
  logic               nmiDly;
  logic               nmiPend;
  logic [VEC_W-1:0]   vecReg, vecNext;
  logic               isNmiReg, isNmiNext;

  logic [NUM_IRQ-1:0] eligible;
  logic               anyEligible;
  logic [VEC_W-1:0]   lowestIdx;
  logic               ackTake;
  logic [NUM_IRQ-1:0] clrVec;
  logic [NUM_IRQ-1:0] pendNext;

  assign eligible    = bus.intd ? '0 : (pendReg & ~maskReg);
  assign anyEligible = |eligible;
  assign ackTake     = (state == REQ) && bus.int_ack;
  assign clrVec      = (ackTake && !isNmiReg) ? (NUM_IRQ'(1) << vecReg) : '0;

  // Scan from the top down so the lowest set index is the one that sticks.
  always_comb begin
    lowestIdx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) lowestIdx = VEC_W'(i);
    end
  end

  // Set term is OR'ed after the clear so a same-cycle edge wins.
  always_comb begin
    if (EDGE_MODE) pendNext = (pendReg & ~clrVec) | (bus.irq & ~irqDly);
    else           pendNext = bus.irq;
  end

  always_comb begin
    stateNext = state;
    vecNext   = vecReg;
    isNmiNext = isNmiReg;
    case (state)
      IDLE: begin
        if (nmiPend) begin
          stateNext = REQ;
          isNmiNext = 1'b1;
          vecNext   = '0;
        end else if (anyEligible) begin
          stateNext = REQ;
          isNmiNext = 1'b0;
          vecNext   = lowestIdx;
        end
      end
      REQ:     if (bus.int_ack) stateNext = SERVICE;
      SERVICE: if (bus.eoi)     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      irqDly   <= '0;
      pendReg  <= '0;
      maskReg  <= '1;
      nmiDly   <= 1'b0;
      nmiPend  <= 1'b0;
      vecReg   <= '0;
      isNmiReg <= 1'b0;
    end else begin
      state    <= stateNext;
      irqDly   <= bus.irq;
      pendReg  <= pendNext;
      nmiDly   <= bus.nmi;
      nmiPend  <= (bus.nmi & ~nmiDly) | (nmiPend & ~(ackTake & isNmiReg));
      vecReg   <= vecNext;
      isNmiReg <= isNmiNext;
      if (bus.mask_we) maskReg <= bus.mask_wdata;
    end
  end

  // Every output is a register or a decode of the state register.
  assign bus.int_req    = (state == REQ);
  assign bus.in_service = (state == SERVICE);
  assign bus.int_vector = vecReg;
  assign bus.int_is_nmi = isNmiReg;
  assign bus.pending    = pendReg;
  assign bus.mask       = maskReg;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
module tb_irq_priority_ctrl;
  logic clk;
  logic reset;
  int   passCnt;
  int   totalCnt;
  logic [3:0] qE[$];
  logic [3:0] qL[$];

  irq_priority_ctrl_if #(.NUM_IRQ(8), .VEC_W(3)) busE ();
  irq_priority_ctrl_if #(.NUM_IRQ(8), .VEC_W(3)) busL ();

  irq_priority_ctrl #(.NUM_IRQ(8), .VEC_W(3), .EDGE_MODE(1'b1)) dutEdge (
    .clk(clk), .reset(reset), .bus(busE)
  );
  irq_priority_ctrl #(.NUM_IRQ(8), .VEC_W(3), .EDGE_MODE(1'b0)) dutLevel (
    .clk(clk), .reset(reset), .bus(busL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ackE();
    busE.int_ack = 1'b1; tick(); busE.int_ack = 1'b0;
  endtask

  task automatic eoiE();
    busE.eoi = 1'b1; tick(); busE.eoi = 1'b0;
  endtask

  // Monitor: each new request presented by a DUT is compared with the
  // oldest expectation queued for that DUT ({is_nmi, vector}).
  initial begin
    logic prevE, prevL;
    logic [3:0] exp;
    prevE = 1'b0;
    prevL = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prevE = 1'b0;
        prevL = 1'b0;
      end else begin
        if (busE.int_req && !prevE) begin
          if (qE.size() == 0) chk("unexpected_req_edge", 1, 0);
          else begin
            exp = qE.pop_front();
            chk("req_edge", {busE.int_is_nmi, busE.int_vector}, exp);
          end
        end
        if (busL.int_req && !prevL) begin
          if (qL.size() == 0) chk("unexpected_req_level", 1, 0);
          else begin
            exp = qL.pop_front();
            chk("req_level", {busL.int_is_nmi, busL.int_vector}, exp);
          end
        end
        prevE = busE.int_req;
        prevL = busL.int_req;
      end
    end
  end

  initial begin
    passCnt  = 0;
    totalCnt = 0;
    reset    = 1'b1;
    busE.irq = '0; busE.nmi = 0; busE.intd = 0; busE.mask_we = 0;
    busE.mask_wdata = '0; busE.int_ack = 0; busE.eoi = 0;
    busL.irq = '0; busL.nmi = 0; busL.intd = 0; busL.mask_we = 0;
    busL.mask_wdata = '0; busL.int_ack = 0; busL.eoi = 0;
    tick(); tick();
    reset = 1'b0;

    // Reset state, then an all-ones mask write with no stimulus
    chk("rst_int_req", busE.int_req, 0);
    chk("rst_mask", busE.mask, 8'hFF);
    chk("rst_pending", busE.pending, 0);
    busE.mask_we = 1; busE.mask_wdata = 8'hFF; tick(); busE.mask_we = 0;
    tick();
    chk("ff_int_req", busE.int_req, 0);
    chk("ff_mask", busE.mask, 8'hFF);

    // Unmask all, pulse irq[5]
    busE.mask_we = 1; busE.mask_wdata = 8'h00; tick(); busE.mask_we = 0;
    chk("mask_zero", busE.mask, 8'h00);
    qE.push_back(4'h5);
    busE.irq = 8'h20; tick(); busE.irq = 8'h00;
    chk("irq5_pending", busE.pending, 8'h20);
    chk("irq5_no_req_yet", busE.int_req, 0);
    tick();
    chk("irq5_req", busE.int_req, 1);
    chk("irq5_vec", busE.int_vector, 5);
    ackE();
    chk("irq5_in_service", busE.in_service, 1);
    chk("irq5_req_drop", busE.int_req, 0);
    chk("irq5_pend_clr", busE.pending, 8'h00);
    eoiE();
    chk("irq5_eoi", busE.in_service, 0);

    // irq[6] and irq[2] together: 2 first, 6 after eoi
    qE.push_back(4'h2);
    qE.push_back(4'h6);
    busE.irq = 8'h44; tick(); busE.irq = 8'h00;
    chk("dual_pending", busE.pending, 8'h44);
    tick();
    chk("dual_vec2", busE.int_vector, 2);
    ackE();
    chk("dual_pend_after_ack", busE.pending, 8'h40);
    eoiE();
    chk("dual_gap_req", busE.int_req, 0);
    tick();
    chk("dual_req6", busE.int_req, 1);
    chk("dual_vec6", busE.int_vector, 6);
    ackE(); eoiE();
    chk("dual_pend_empty", busE.pending, 8'h00);

    // NMI bypasses intd; maskable waits for intd release
    busE.intd = 1;
    qE.push_back(4'h8);
    qE.push_back(4'h1);
    busE.irq = 8'h02; tick(); busE.irq = 8'h00;
    tick();
    chk("intd_blocks", busE.int_req, 0);
    busE.nmi = 1; tick(); busE.nmi = 0;
    tick();
    chk("nmi_req", busE.int_req, 1);
    chk("nmi_flag", busE.int_is_nmi, 1);
    chk("nmi_vec", busE.int_vector, 0);
    ackE(); eoiE();
    tick(); tick(); tick();
    chk("intd_hold", busE.int_req, 0);
    busE.intd = 0; tick();
    chk("intd_release_req", busE.int_req, 1);
    chk("intd_release_vec", busE.int_vector, 1);
    ackE(); eoiE();

    // Frozen request for vector 3 survives a mask write and an NMI
    qE.push_back(4'h3);
    qE.push_back(4'h8);
    busE.irq = 8'h08; tick(); busE.irq = 8'h00;
    tick();
    busE.mask_we = 1; busE.mask_wdata = 8'h08; busE.nmi = 1; tick();
    busE.mask_we = 0; busE.nmi = 0;
    tick();
    chk("frozen_req", busE.int_req, 1);
    chk("frozen_vec", busE.int_vector, 3);
    chk("frozen_not_nmi", busE.int_is_nmi, 0);
    chk("frozen_mask", busE.mask, 8'h08);
    ackE(); eoiE();
    tick();
    chk("post_frozen_nmi", busE.int_is_nmi, 1);
    chk("post_frozen_req", busE.int_req, 1);
    ackE(); eoiE();
    busE.mask_we = 1; busE.mask_wdata = 8'h00; tick(); busE.mask_we = 0;

    // Level-mode DUT: held irq[4] re-requests at eoi+2; strays ignored
    busL.mask_we = 1; busL.mask_wdata = 8'h00; tick(); busL.mask_we = 0;
    qL.push_back(4'h4);
    qL.push_back(4'h4);
    busL.irq = 8'h10; tick();
    chk("lvl_pending", busL.pending, 8'h10);
    tick();
    chk("lvl_vec", busL.int_vector, 4);
    busL.eoi = 1; tick(); busL.eoi = 0;
    chk("lvl_stray_eoi_req", busL.int_req, 1);
    chk("lvl_stray_eoi_svc", busL.in_service, 0);
    busL.int_ack = 1; tick(); busL.int_ack = 0;
    chk("lvl_svc", busL.in_service, 1);
    chk("lvl_pend_kept", busL.pending, 8'h10);
    busL.eoi = 1; tick(); busL.eoi = 0;
    chk("lvl_eoi1_req", busL.int_req, 0);
    tick();
    chk("lvl_rereq", busL.int_req, 1);
    chk("lvl_rereq_vec", busL.int_vector, 4);
    busL.irq = 8'h00;
    busL.int_ack = 1; tick(); busL.int_ack = 0;
    busL.eoi = 1; tick(); busL.eoi = 0;
    busL.int_ack = 1; tick(); busL.int_ack = 0;
    chk("lvl_stray_ack_req", busL.int_req, 0);
    chk("lvl_stray_ack_svc", busL.in_service, 0);
    tick();
    chk("lvl_idle_stays", busL.int_req, 0);

    // Reset during SERVICE
    qE.push_back(4'h0);
    busE.irq = 8'h01; tick(); busE.irq = 8'h00;
    tick();
    ackE();
    chk("rst_svc_pre", busE.in_service, 1);
    busE.irq = 8'h80; tick(); busE.irq = 8'h00;
    chk("rst_svc_pend_pre", busE.pending, 8'h80);
    reset = 1; tick(); reset = 0;
    chk("rst_svc_in_service", busE.in_service, 0);
    chk("rst_svc_pending", busE.pending, 8'h00);
    chk("rst_svc_mask", busE.mask, 8'hFF);
    chk("rst_svc_req", busE.int_req, 0);
    tick(); tick();
    chk("rst_svc_quiet", busE.int_req, 0);

    chk("queue_edge_empty", qE.size(), 0);
    chk("queue_level_empty", qL.size(), 0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
